// File: rtl/bcrypt_outpkt_builder_pkg.sv
// Shared constants and types for the bcrypt output packet builder.
package bcrypt_outpkt_builder_pkg;

  localparam int OUTPKT_TYPE_MSB = 2;
  localparam int HASH_NUM_MSB    = 7;

  localparam logic [7:0] OUTPKT_VERSION      = 8'h02;
  localparam logic [7:0] PKT_TYPE_RESULT     = 8'h01;
  localparam logic [7:0] PKT_TYPE_CMP_RESULT = 8'h02;
  localparam logic [7:0] PKT_TYPE_DONE       = 8'h03;

  localparam int OUTPKT_HDR_LEN  = 4;
  localparam int OUTPKT_CSUM_LEN = 2;

  // Record type encodings as presented by the arbiter.
  localparam logic [OUTPKT_TYPE_MSB:0] OUTPKT_TYPE_RESULT      = 3'd1;
  localparam logic [OUTPKT_TYPE_MSB:0] OUTPKT_TYPE_CMP_RESULT  = 3'd2;
  localparam logic [OUTPKT_TYPE_MSB:0] OUTPKT_TYPE_PACKET_DONE = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_HEADER,
    ST_BODY,
    ST_CSUM,
    ST_ACK
  } state_t;

  typedef enum logic [1:0] {
    BODY_RESULT,
    BODY_CMP,
    BODY_DONE
  } body_kind_t;

endpackage

// File: rtl/bcrypt_outpkt_builder_checksum.sv
// 32-bit wrapping accumulator of emitted 16-bit words, with inverted readout.
module outpkt_checksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add,
  input  logic [15:0] data,
  output logic [31:0] sum_inv
);

  logic [31:0] sum;

  assign sum_inv = ~sum;

  // Clear takes priority; otherwise accumulate zero-extended words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + {16'h0000, data};
    end
  end

endmodule

// File: rtl/bcrypt_outpkt_builder.sv
// Serializes one arbiter output record into a header/body/checksum word frame.
module bcrypt_outpkt_builder
  import bcrypt_outpkt_builder_pkg::*;
(
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [OUTPKT_TYPE_MSB:0] outpkt_type,
  input  logic [15:0]              din,
  output logic [3:0]               rd_addr,
  input  logic [15:0]              pkt_id,
  input  logic [31:0]              num_processed,
  input  logic [HASH_NUM_MSB:0]    hash_num,
  input  logic                     empty,
  output logic                     rd_en,
  output logic [15:0]              dout,
  output logic                     wr_en,
  input  logic                     full,
  output logic                     err_type,
  output logic                     busy
);

  state_t                state;
  body_kind_t            kind;
  logic [7:0]            code;
  logic [4:0]            len;
  logic [4:0]            cnt;
  logic [15:0]           id_q;
  logic [31:0]           np_q;
  logic [HASH_NUM_MSB:0] hash_q;
  logic [15:0]           word;
  logic [31:0]           csum_inv;
  logic                  csum_clr;
  logic                  csum_add;

  assign busy     = (state != ST_IDLE);
  assign csum_clr = (state == ST_LATCH);
  assign csum_add = !full && ((state == ST_HEADER) || (state == ST_BODY));

  outpkt_checksum u_csum (
    .clk     (CLK),
    .rst     (rst),
    .clr     (csum_clr),
    .add     (csum_add),
    .data    (word),
    .sum_inv (csum_inv)
  );

  // Field mux: the word that would be emitted at the next accepted edge.
  always_comb begin
    word = '0;
    case (state)
      ST_HEADER: begin
        case (cnt[1:0])
          2'd0:    word = {OUTPKT_VERSION, code};
          2'd1:    word = id_q;
          2'd2:    word = {11'b0, len};
          default: word = '0;
        endcase
      end
      ST_BODY: begin
        case (kind)
          BODY_RESULT: word = din;
          BODY_CMP: begin
            if (cnt < 5'd4)       word = din;
            else if (cnt == 5'd4) word = 16'(hash_q);
            else                  word = '0;
          end
          default: word = (cnt == 5'd0) ? np_q[15:0] : np_q[31:16];
        endcase
      end
      ST_CSUM: word = (cnt == 5'd0) ? csum_inv[15:0] : csum_inv[31:16];
      default: word = '0;
    endcase
  end

  // Frame sequencer with registered outputs; words advance only when not full.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      kind     <= BODY_RESULT;
      code     <= '0;
      len      <= '0;
      cnt      <= '0;
      id_q     <= '0;
      np_q     <= '0;
      hash_q   <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      err_type <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The ack cycle itself is skipped so a still-low empty cannot re-trigger.
          if (!empty && !rd_en) state <= ST_LATCH;
        end
        ST_LATCH: begin
          id_q    <= pkt_id;
          np_q    <= num_processed;
          hash_q  <= hash_num;
          cnt     <= '0;
          rd_addr <= '0;
          state   <= ST_HEADER;
          case (outpkt_type)
            OUTPKT_TYPE_RESULT: begin
              kind <= BODY_RESULT;
              code <= PKT_TYPE_RESULT;
              len  <= 5'd16;
            end
            OUTPKT_TYPE_CMP_RESULT: begin
              kind <= BODY_CMP;
              code <= PKT_TYPE_CMP_RESULT;
              len  <= 5'd6;
            end
            OUTPKT_TYPE_PACKET_DONE: begin
              kind <= BODY_DONE;
              code <= PKT_TYPE_DONE;
              len  <= 5'd2;
            end
            default: begin
              err_type <= 1'b1;
              state    <= ST_ACK;
            end
          endcase
        end
        ST_HEADER: begin
          if (!full) begin
            dout  <= word;
            wr_en <= 1'b1;
            if (cnt == 5'(OUTPKT_HDR_LEN - 1)) begin
              cnt   <= '0;
              state <= ST_BODY;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        ST_BODY: begin
          if (!full) begin
            dout    <= word;
            wr_en   <= 1'b1;
            rd_addr <= rd_addr + 4'd1;
            if (cnt == len - 5'd1) begin
              cnt   <= '0;
              state <= ST_CSUM;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        ST_CSUM: begin
          if (!full) begin
            dout  <= word;
            wr_en <= 1'b1;
            if (cnt == 5'(OUTPKT_CSUM_LEN - 1)) begin
              cnt   <= '0;
              state <= ST_ACK;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        ST_ACK: begin
          rd_en <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcrypt_outpkt_builder.sv
// Directed bench for bcrypt_outpkt_builder: framing, checksum, backpressure, reset, errors.
module tb_bcrypt_outpkt_builder;

  logic        CLK = 1'b0;
  logic        rst;
  logic [2:0]  outpkt_type;
  logic [15:0] din;
  logic [3:0]  rd_addr;
  logic [15:0] pkt_id;
  logic [31:0] num_processed;
  logic [7:0]  hash_num;
  logic        empty;
  logic        rd_en;
  logic [15:0] dout;
  logic        wr_en;
  logic        full;
  logic        err_type;
  logic        busy;

  logic [15:0] mem [16];
  assign din = mem[rd_addr];

  always #5 CLK = ~CLK;

  bcrypt_outpkt_builder dut (
    .CLK           (CLK),
    .rst           (rst),
    .outpkt_type   (outpkt_type),
    .din           (din),
    .rd_addr       (rd_addr),
    .pkt_id        (pkt_id),
    .num_processed (num_processed),
    .hash_num      (hash_num),
    .empty         (empty),
    .rd_en         (rd_en),
    .dout          (dout),
    .wr_en         (wr_en),
    .full          (full),
    .err_type      (err_type),
    .busy          (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] got [$];
  int rd_cnt;
  int viol;
  int cyc_rd;

  // Collect emitted words until rd_en, then watch 4 more cycles for a second ack.
  task automatic capture(input bit rand_full, input int budget);
    bit pf;
    int post;
    got.delete();
    rd_cnt = 0;
    viol   = 0;
    cyc_rd = -1;
    post   = -1;
    pf     = full;
    for (int k = 1; k <= budget; k++) begin
      @(negedge CLK);
      if (wr_en) begin
        got.push_back(dout);
        if (pf) viol++;
      end
      if (rd_en) begin
        rd_cnt++;
        if (cyc_rd < 0) cyc_rd = k - 1;
        empty = 1'b1;
      end
      if (rand_full && cyc_rd < 0) full = 1'($urandom_range(0, 1));
      else full = 1'b0;
      pf = full;
      if (cyc_rd >= 0) begin
        if (post < 0) post = k;
        else if (k - post >= 4) break;
      end
    end
  endtask

  // Reference frame: header, body, then inverted 32-bit sum of header+body.
  task automatic build_exp(input logic [7:0] code, input logic [15:0] id,
                           input logic [15:0] body [$], output logic [15:0] exp [$]);
    logic [31:0] s;
    exp.delete();
    exp.push_back({8'h02, code});
    exp.push_back(id);
    exp.push_back(16'(body.size()));
    exp.push_back(16'h0000);
    foreach (body[i]) exp.push_back(body[i]);
    s = 32'h0;
    foreach (exp[i]) s = s + {16'h0, exp[i]};
    s = ~s;
    exp.push_back(s[15:0]);
    exp.push_back(s[31:16]);
  endtask

  function automatic int frame_diff(input logic [15:0] exp [$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (i >= got.size()) return i;
      if (got[i] !== exp[i]) return i;
    end
    if (got.size() != exp.size()) return exp.size();
    return -1;
  endfunction

  task automatic start_record(input logic [2:0] t, input logic [15:0] id,
                              input logic [31:0] np, input logic [7:0] h);
    @(negedge CLK);
    outpkt_type   = t;
    pkt_id        = id;
    num_processed = np;
    hash_num      = h;
    empty         = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    empty = 1'b1;
    full = 1'b0;
    outpkt_type = 3'd0;
    pkt_id = '0;
    num_processed = '0;
    hash_num = '0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    repeat (3) @(negedge CLK);
    n_assert++;
    if ({wr_en, rd_en, busy, err_type, dout, rd_addr} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: wr_en=%b rd_en=%b busy=%b err=%b dout=%h rd_addr=%h, want all 0",
               wr_en, rd_en, busy, err_type, dout, rd_addr);
    end
    rst = 1'b0;
    @(negedge CLK);
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b want 0", busy);
    end
  endtask

  task automatic test_done();
    logic [15:0] exp [$];
    int d;
    exp = '{16'h0203, 16'h1234, 16'h0002, 16'h0000, 16'h0005, 16'h0001, 16'hEBC0, 16'hFFFF};
    start_record(3'd3, 16'h1234, 32'h0001_0005, 8'h00);
    capture(1'b0, 60);
    d = frame_diff(exp);
    n_assert++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL done_frame: diff at word %0d, got %0d words (word=%h) want %h",
               d, got.size(), (d < got.size()) ? got[d] : 16'hxxxx, (d < exp.size()) ? exp[d] : 16'hxxxx);
    end
    n_assert++;
    if (rd_cnt !== 1) begin
      n_fail++;
      $display("FAIL done_rd_en_count: got %0d want 1", rd_cnt);
    end
    n_assert++;
    if (cyc_rd !== 10) begin
      n_fail++;
      $display("FAIL done_latency: got %0d cycles want 10", cyc_rd);
    end
  endtask

  task automatic test_result(input bit rand_full);
    logic [15:0] body [$];
    logic [15:0] exp [$];
    int d;
    body.delete();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 16'hA000 + 16'(i);
      body.push_back(16'hA000 + 16'(i));
    end
    build_exp(8'h01, 16'hBEEF, body, exp);
    start_record(3'd1, 16'hBEEF, 32'hDEAD_0000, 8'h07);
    capture(rand_full, 400);
    d = frame_diff(exp);
    n_assert++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL result_frame(full=%0b): diff at word %0d, got %0d words (word=%h) want %h",
               rand_full, d, got.size(), (d < got.size()) ? got[d] : 16'hxxxx, (d < exp.size()) ? exp[d] : 16'hxxxx);
    end
    n_assert++;
    if (rd_cnt !== 1) begin
      n_fail++;
      $display("FAIL result_rd_en_count(full=%0b): got %0d want 1", rand_full, rd_cnt);
    end
    n_assert++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL result_write_while_full: got %0d writes want 0", viol);
    end
    if (!rand_full) begin
      n_assert++;
      if (cyc_rd !== 24) begin
        n_fail++;
        $display("FAIL result_latency: got %0d cycles want 24", cyc_rd);
      end
    end
  endtask

  task automatic test_cmp();
    logic [15:0] body [$];
    logic [15:0] exp [$];
    int d;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    for (int i = 4; i < 16; i++) mem[i] = 16'hFFFF;
    body = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0005, 16'h0000};
    build_exp(8'h02, 16'h0042, body, exp);
    start_record(3'd2, 16'h0042, 32'h0, 8'h05);
    capture(1'b0, 60);
    d = frame_diff(exp);
    n_assert++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL cmp_frame: diff at word %0d, got %0d words (word=%h) want %h",
               d, got.size(), (d < got.size()) ? got[d] : 16'hxxxx, (d < exp.size()) ? exp[d] : 16'hxxxx);
    end
    n_assert++;
    if (got.size() < 3 || got[2] !== 16'h0006) begin
      n_fail++;
      $display("FAIL cmp_length_word: got %h want 0006", (got.size() >= 3) ? got[2] : 16'hxxxx);
    end
    n_assert++;
    if (rd_cnt !== 1) begin
      n_fail++;
      $display("FAIL cmp_rd_en_count: got %0d want 1", rd_cnt);
    end
  endtask

  task automatic test_rst_mid();
    logic [15:0] body [$];
    logic [15:0] exp [$];
    int d;
    int early_rd;
    int nw;
    body.delete();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 16'h5000 + 16'(i * 3);
      body.push_back(16'h5000 + 16'(i * 3));
    end
    build_exp(8'h01, 16'h7777, body, exp);
    start_record(3'd1, 16'h7777, 32'h0, 8'h00);
    early_rd = 0;
    nw = 0;
    for (int k = 0; k < 20 && nw < 3; k++) begin
      @(negedge CLK);
      if (wr_en) nw++;
      if (rd_en) early_rd++;
    end
    rst = 1'b1;
    #1;
    n_assert++;
    if ({wr_en, rd_en, busy, dout, rd_addr} !== 23'h0 || nw !== 3) begin
      n_fail++;
      $display("FAIL midframe_reset_clear: words_before=%0d wr_en=%b rd_en=%b busy=%b dout=%h rd_addr=%h, want 3 and all 0",
               nw, wr_en, rd_en, busy, dout, rd_addr);
    end
    @(negedge CLK);
    rst = 1'b0;
    capture(1'b0, 80);
    d = frame_diff(exp);
    n_assert++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL midframe_reframe: diff at word %0d, got %0d words (word=%h) want %h",
               d, got.size(), (d < got.size()) ? got[d] : 16'hxxxx, (d < exp.size()) ? exp[d] : 16'hxxxx);
    end
    n_assert++;
    if (rd_cnt + early_rd !== 1) begin
      n_fail++;
      $display("FAIL midframe_rd_en_count: got %0d want 1", rd_cnt + early_rd);
    end
  endtask

  task automatic test_unknown();
    logic [15:0] body [$];
    logic [15:0] exp [$];
    int d;
    start_record(3'd6, 16'h9999, 32'h0, 8'h00);
    capture(1'b0, 30);
    n_assert++;
    if (got.size() !== 0) begin
      n_fail++;
      $display("FAIL unknown_no_words: got %0d words want 0", got.size());
    end
    n_assert++;
    if (rd_cnt !== 1) begin
      n_fail++;
      $display("FAIL unknown_rd_en_count: got %0d want 1", rd_cnt);
    end
    n_assert++;
    if (err_type !== 1'b1) begin
      n_fail++;
      $display("FAIL unknown_err_set: got %b want 1", err_type);
    end
    body = '{16'hCAFE, 16'h0000};
    build_exp(8'h03, 16'h0001, body, exp);
    start_record(3'd3, 16'h0001, 32'h0000_CAFE, 8'h00);
    capture(1'b0, 60);
    d = frame_diff(exp);
    n_assert++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL after_unknown_frame: diff at word %0d, got %0d words (word=%h) want %h",
               d, got.size(), (d < got.size()) ? got[d] : 16'hxxxx, (d < exp.size()) ? exp[d] : 16'hxxxx);
    end
    n_assert++;
    if (err_type !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", err_type);
    end
  endtask

  initial begin
    test_reset();
    test_done();
    test_result(1'b0);
    test_cmp();
    test_result(1'b1);
    test_rst_mid();
    test_unknown();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
